mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: in  input  execute_data_t  EX/MEM register contents (j_addr, memdata, result, ctl).
REQ-004 SHALL have port: in_valid  input  1  in holds a live instruction.
REQ-005 SHALL have port: dreq  output  dbus_req_t  data-bus request (valid, addr, size, strobe, data).
REQ-006 SHALL have port: dresp  input  dbus_resp_t  data-bus response (addr_ok, data_ok, data).
REQ-007 SHALL have port: out  output  memory_data_t  registered MEM/WB contents (regwrite, dst, regdata).
REQ-008 SHALL have port: out_valid  output  1  out holds a live instruction.
REQ-009 SHALL have port: stall  output  1  freeze request to fetch/decode/execute and the EX/MEM register.
REQ-010 SHALL have port: fwd  output  forward_data_out  MEM-stage forwarding source.
REQ-011 SHALL have port: misalign  output  1  registered one-cycle misaligned-access flag.

Function
REQ-012 SHALL classify in as a memory op when in_valid=1 and (ctl.memread=1 or ctl.memwrite=1).
REQ-013 SHALL implement FSM states IDLE and WAIT; IDLE->WAIT when a memory op is presented and dresp.data_ok=0; WAIT->IDLE on dresp.data_ok=1; all other cases hold state.
REQ-014 SHALL drive dreq.valid=1 combinationally in IDLE on a memory op and continuously in WAIT until the data_ok cycle inclusive.
REQ-015 SHALL drive dreq.addr=in.result, dreq.size=3'b011 (8 bytes), and keep all dreq fields stable while dreq.valid=1.
REQ-016 SHALL drive, for stores, dreq.strobe=8'hFF and dreq.data=in.memdata; for loads, dreq.strobe=8'h00; dreq.data is don't-care for loads.
REQ-017 SHALL drive stall=1 whenever dreq.valid=1 and dresp.data_ok=0; stall=0 otherwise; zero-wait response (data_ok in the issue cycle) completes with no stall.
REQ-018 SHALL treat dresp.addr_ok as informational only; completion is solely dresp.data_ok.
REQ-019 SHALL update out on the rising edge when in_valid=1 and stall=0: regwrite=in.ctl.regwrite, dst=in.ctl.dst, regdata=dresp.data for loads else in.result; out_valid<=1.
REQ-020 SHALL load a bubble (out_valid<=0, out.regwrite<=0) when in_valid=0 or stall=1.
REQ-021 SHALL drive fwd.valid=1 only when in_valid=1, ctl.regwrite=1, dst!=0, and (non-load or load with dresp.data_ok=1); fwd.data equals the value REQ-019 would register.
REQ-022 SHALL never issue a second request for the same instruction; issue latency is 0 cycles, total load-use latency is 1 + bus wait cycles.
REQ-023 SHALL ignore dresp.data_ok in IDLE when no memory op is presented.

Reset
REQ-024 SHALL, on reset=1, force FSM=IDLE, out=0, out_valid=0, misalign=0 on the next edge, regardless of an outstanding bus transaction.
REQ-025 SHALL hold dreq.valid=0 and stall=0 combinationally while reset=1.
REQ-026 SHALL discard any dresp.data_ok arriving after reset aborted a transaction.

Configuration
REQ-027 SHALL, with MEM_MISALIGN_CHECK_EN defined, treat a memory op with in.result[2:0]!=0 as misaligned: no dreq.valid, no stall, out.regwrite<=0, out_valid<=1, misalign<=1 for one cycle.
REQ-028 SHALL, without MEM_MISALIGN_CHECK_EN, issue all addresses unchanged and tie misalign to 0.

Verification
REQ-029 SHALL cover: load addr 0x80001000, data_ok after 3 cycles with data 0xDEADBEEF00000001 -> stall=1 for exactly 3 cycles, dreq stable, then out.regdata=0xDEADBEEF00000001, dst as issued.
REQ-030 SHALL cover: store addr 0x80000008 data 0x1234, data_ok same cycle -> strobe=8'hFF, stall never 1, out.regwrite=0, out_valid=1.
REQ-031 SHALL cover: ADD result 0x42 to x5, no memory op -> dreq.valid=0, fwd={1,5,0x42}, out next cycle regdata=0x42.
REQ-032 SHALL cover: reset asserted in WAIT with late data_ok -> dreq.valid=0, FSM IDLE, out_valid=0, late data_ok ignored.
REQ-033 SHALL cover: MEM_MISALIGN_CHECK_EN defined, load addr 0x80000004 -> no request, misalign=1 one cycle, out.regwrite=0; undefined -> request issued at 0x80000004.
REQ-034 SHALL cover: back-to-back loads with data_ok each 1 cycle late -> exactly two requests, each stall one cycle, two valid outputs in order.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of an in-order core.
// It issues one 8-byte data-bus request per load/store, freezes the upstream
// pipeline while the response is outstanding, and registers the MEM/WB result.
// It also provides the MEM-stage forwarding source.
// Optional build macro: MEM_MISALIGN_CHECK_EN.
//   When defined, memory ops whose address is not 8-byte aligned are not issued.
//   Instead they retire as flagged non-writing instructions.

package mem_stage_pkg;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [4:0] dst;
    } ctl_t;

    typedef struct packed {
        logic [63:0] j_addr;
        logic [63:0] memdata;
        logic [63:0] result;
        ctl_t        ctl;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        regwrite;
        logic [4:0]  dst;
        logic [63:0] regdata;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dst;
        logic [63:0] data;
    } forward_data_out;

endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  execute_data_t   in,
    input  logic            in_valid,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output memory_data_t    out,
    output logic            out_valid,
    output logic            stall,
    output forward_data_out fwd,
    output logic            misalign
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t       state_reg;
    state_t       state_next;

    memory_data_t out_reg;
    logic         out_valid_reg;
    logic         misalign_reg;

    logic         is_memop;
    logic         is_load;
    logic         misaligned;
    logic         issue;
    logic         req_valid;
    logic [63:0]  wb_data;

    // The jump address travels with the instruction but is not needed here.
    // The address handshake is informational only; completion is data_ok.
    logic         unused_bits;
    assign unused_bits = ^{in.j_addr, dresp.addr_ok};

    assign is_memop = in_valid && (in.ctl.memread || in.ctl.memwrite);
    assign is_load  = in.ctl.memread;

`ifdef MEM_MISALIGN_CHECK_EN
    // Unaligned doublewords are retired as faults and never reach the bus.
    assign misaligned = is_memop && (in.result[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    assign issue = is_memop && !misaligned;

    // The request is raised on a fresh memory op in IDLE.
    // It is held through WAIT until the data_ok cycle.
    // The EX/MEM register is frozen by stall, so all fields stay stable.
    assign req_valid = !reset && ((state_reg == IDLE && issue) || (state_reg == WAIT));

    // Loads write back the bus data; everything else writes back the ALU result.
    assign wb_data = is_load ? dresp.data : in.result;

    // Drive the bus request, the stall and the next FSM state.
    always_comb begin
        dreq       = '0;
        stall      = 1'b0;
        state_next = state_reg;

        if (req_valid) begin
            dreq.valid  = 1'b1;
            dreq.addr   = in.result;
            dreq.size   = 3'b011;
            dreq.strobe = in.ctl.memwrite ? 8'hFF : 8'h00;
            dreq.data   = in.memdata;
            stall       = !dresp.data_ok;
        end

        case (state_reg)
            IDLE: begin
                if (issue && !dresp.data_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (dresp.data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (reset) begin
            state_next = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // MEM/WB register.
    // It captures the retiring instruction, a misaligned fault, or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            misalign_reg <= misaligned;
            if (misaligned) begin
                out_reg.regwrite <= 1'b0;
                out_reg.dst      <= in.ctl.dst;
                out_reg.regdata  <= in.result;
                out_valid_reg    <= 1'b1;
            end else if (in_valid && !stall) begin
                out_reg.regwrite <= in.ctl.regwrite;
                out_reg.dst      <= in.ctl.dst;
                out_reg.regdata  <= wb_data;
                out_valid_reg    <= 1'b1;
            end else begin
                out_reg.regwrite <= 1'b0;
                out_valid_reg    <= 1'b0;
            end
        end
    end

    // Forwarding source.
    // A load only forwards in the cycle its data actually arrives.
    always_comb begin
        fwd       = '0;
        fwd.dst   = in.ctl.dst;
        fwd.data  = wb_data;
        fwd.valid = in_valid && in.ctl.regwrite && (in.ctl.dst != 5'd0) && !misaligned
                    && (!is_load || (req_valid && dresp.data_ok));
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign misalign  = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
// Covers ALU pass-through, a waited load, a zero-wait store,
// back-to-back loads, the misaligned access and reset during WAIT.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    execute_data_t   in;
    logic            in_valid;
    dbus_req_t       dreq;
    dbus_resp_t      dresp;
    memory_data_t    out;
    logic            out_valid;
    logic            stall;
    forward_data_out fwd;
    logic            misalign;

    int n_vec = 0;
    int n_bad = 0;
    int req_count;
    logic prev_valid;
    logic prev_ok;

    mem_stage dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .dreq     (dreq),
        .dresp    (dresp),
        .out      (out),
        .out_valid(out_valid),
        .stall    (stall),
        .fwd      (fwd),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic [4:0] dst, input logic [63:0] res, input logic [63:0] md);
        in_valid        = v;
        in.j_addr       = 64'h0;
        in.memdata      = md;
        in.result       = res;
        in.ctl.memread  = rd;
        in.ctl.memwrite = wr;
        in.ctl.regwrite = rw;
        in.ctl.dst      = dst;
    endtask

    task automatic set_resp(input logic ok, input logic [63:0] d);
        dresp.addr_ok = ok;
        dresp.data_ok = ok;
        dresp.data    = d;
    endtask

    // Count new requests: a valid cycle not continuing an earlier pending request.
    task automatic note_req();
        if (dreq.valid && (!prev_valid || prev_ok)) req_count++;
        prev_valid = dreq.valid;
        prev_ok    = dresp.data_ok;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 64'h8000_1000, 64'h0);
        set_resp(1'b0, 64'h0);
        #2;
        check("rst_dreq_valid", 64'(dreq.valid), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out", 64'(out), 64'h0);
        check("rst_misalign", 64'(misalign), 64'h0);

        // ALU result 0x42 written to x5.
        reset = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 64'h42, 64'h0);
        #1;
        check("add_dreq_valid", 64'(dreq.valid), 64'h0);
        check("add_stall", 64'(stall), 64'h0);
        check("add_fwd", 64'({fwd.valid, fwd.dst}), 64'({1'b1, 5'd5}));
        check("add_fwd_data", fwd.data, 64'h42);
        tick();
        check("add_out_valid", 64'(out_valid), 64'h1);
        check("add_out_regdata", out.regdata, 64'h42);
        check("add_out_dst_rw", 64'({out.regwrite, out.dst}), 64'({1'b1, 5'd5}));

        // A write to x0 must not be forwarded.
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 64'h99, 64'h0);
        #1;
        check("x0_fwd_valid", 64'(fwd.valid), 64'h0);
        tick();

        // Load from 0x80001000; data_ok arrives after 3 stall cycles.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 64'h8000_1000, 64'h0);
        set_resp(1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ld_stall_c%0d", i), 64'(stall), 64'h1);
            check($sformatf("ld_dreq_c%0d", i), 64'({dreq.valid, dreq.size, dreq.strobe}),
                  64'({1'b1, 3'b011, 8'h00}));
            check($sformatf("ld_addr_c%0d", i), dreq.addr, 64'h8000_1000);
            check($sformatf("ld_fwd_c%0d", i), 64'(fwd.valid), 64'h0);
            tick();
            check($sformatf("ld_bubble_c%0d", i), 64'({out_valid, out.regwrite}), 64'h0);
        end
        set_resp(1'b1, 64'hDEAD_BEEF_0000_0001);
        #1;
        check("ld_done_stall", 64'(stall), 64'h0);
        check("ld_done_dreq", 64'(dreq.valid), 64'h1);
        check("ld_fwd_data", 64'({fwd.valid, fwd.dst}), 64'({1'b1, 5'd7}));
        tick();
        check("ld_out_regdata", out.regdata, 64'hDEAD_BEEF_0000_0001);
        check("ld_out_dst", 64'({out_valid, out.regwrite, out.dst}), 64'({2'b11, 5'd7}));
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        check("ld_idle_dreq", 64'(dreq.valid), 64'h0);
        tick();

        // Store to 0x80000008 with a zero-wait response.
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 64'h8000_0008, 64'h1234);
        set_resp(1'b1, 64'h0);
        #1;
        check("st_dreq", 64'({dreq.valid, dreq.strobe}), 64'({1'b1, 8'hFF}));
        check("st_data", dreq.data, 64'h1234);
        check("st_addr", dreq.addr, 64'h8000_0008);
        check("st_stall", 64'(stall), 64'h0);
        tick();
        check("st_out", 64'({out_valid, out.regwrite}), 64'({1'b1, 1'b0}));

        // Back-to-back loads; each data_ok arrives one cycle late.
        req_count  = 0;
        prev_valid = 1'b0;
        prev_ok    = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 64'h8000_0010, 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        note_req();
        check("b2b_a_stall", 64'(stall), 64'h1);
        tick();
        check("b2b_a_bubble", 64'(out_valid), 64'h0);
        set_resp(1'b1, 64'hAAAA_0000_0000_0003);
        #1;
        note_req();
        check("b2b_a_done", 64'(stall), 64'h0);
        tick();
        check("b2b_a_out", out.regdata, 64'hAAAA_0000_0000_0003);
        check("b2b_a_dst", 64'({out_valid, out.dst}), 64'({1'b1, 5'd3}));
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 64'h8000_0018, 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        note_req();
        check("b2b_b_stall", 64'(stall), 64'h1);
        check("b2b_b_addr", dreq.addr, 64'h8000_0018);
        tick();
        check("b2b_b_bubble", 64'(out_valid), 64'h0);
        set_resp(1'b1, 64'hBBBB_0000_0000_0004);
        #1;
        note_req();
        check("b2b_b_done", 64'(stall), 64'h0);
        tick();
        check("b2b_b_out", out.regdata, 64'hBBBB_0000_0000_0004);
        check("b2b_b_dst", 64'({out_valid, out.dst}), 64'({1'b1, 5'd4}));
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        note_req();
        check("b2b_req_count", 64'(req_count), 64'd2);
        tick();

        // Misaligned load at 0x80000004.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 64'h8000_0004, 64'h0);
`ifdef MEM_MISALIGN_CHECK_EN
        set_resp(1'b0, 64'h0);
        #1;
        check("mis_dreq", 64'({dreq.valid, stall}), 64'h0);
        tick();
        check("mis_flag", 64'({misalign, out_valid, out.regwrite}), 64'b110);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        tick();
        check("mis_flag_clear", 64'(misalign), 64'h0);
`else
        set_resp(1'b1, 64'h0000_0000_5555_6666);
        #1;
        check("mis_dreq", 64'({dreq.valid, stall}), 64'b10);
        check("mis_addr", dreq.addr, 64'h8000_0004);
        tick();
        check("mis_flag", 64'({misalign, out_valid, out.regwrite}), 64'b011);
        check("mis_out_regdata", out.regdata, 64'h0000_0000_5555_6666);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        set_resp(1'b0, 64'h0);
        tick();
`endif

        // Reset arrives while a load is waiting; a late data_ok must be ignored.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 64'h8000_2000, 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        check("rw_stall", 64'(stall), 64'h1);
        tick();
        reset = 1'b1;
        #1;
        check("rw_rst_dreq", 64'({dreq.valid, stall}), 64'h0);
        tick();
        check("rw_rst_out", 64'({out_valid, out.regwrite}), 64'h0);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        set_resp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        check("rw_late_dreq", 64'({dreq.valid, stall, fwd.valid}), 64'h0);
        tick();
        check("rw_late_out", 64'(out_valid), 64'h0);
        set_resp(1'b0, 64'h0);
        #1;
        check("rw_idle_dreq", 64'(dreq.valid), 64'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
